// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: byte width and FSM state encoding.
package uart_pkg;
  localparam int UART_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and uart_tx handshake bundle for uart_tx_arb.
// master = requesters + uart_tx side, slave = the arbiter.
interface uart_tx_arb_if #(
  parameter int N = 4
) ();
  import uart_pkg::*;

  logic [N-1:0]        i_req;
  logic [N*UART_W-1:0] i_data;
  logic [N-1:0]        o_ack;
  logic                o_busy;
  logic                o_valid;
  logic [UART_W-1:0]   o_data;
  logic                i_accept;

  modport master (output i_req, i_data, i_accept, input o_ack, o_busy, o_valid, o_data);
  modport slave  (input i_req, i_data, i_accept, output o_ack, o_busy, o_valid, o_data);
endinterface

// File: rtl/uart_arb_pick.sv
// Combinational requester picker: round-robin from 'start', or fixed
// lowest-index priority when UART_TX_ARB_FIXED_PRIO_EN is defined.
module uart_arb_pick import uart_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic found;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  logic unused_start;
  assign unused_start = ^start;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[IW'(i)]) begin
        found          = 1'b1;
        gnt[IW'(i)]    = 1'b1;
        idx            = IW'(i);
      end
    end
  end
`else
  int k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    // Scan start, start+1, ... wrapping modulo N; first hit wins.
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!found && req[IW'(k)]) begin
        found       = 1'b1;
        gnt[IW'(k)] = 1'b1;
        idx         = IW'(k);
      end
    end
  end
`endif
endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx between N byte requesters; owns the grant FSM, the
// captured byte and the round-robin pointer (unused under UART_TX_ARB_FIXED_PRIO_EN).
module uart_tx_arb import uart_pkg::*; #(
  parameter int N = 4,
  parameter int W = UART_W
) (
  input logic           i_clk,
  input logic           i_rst,
  uart_tx_arb_if.slave  bus
);
  localparam int IW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  gnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] start;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IW-1:0] last_q, last_d;
  assign start = (last_q == IW'(N-1)) ? '0 : last_q + 1'b1;
`endif

  uart_arb_pick #(.N(N), .IW(IW)) u_pick (
    .req   (bus.i_req),
    .start (start),
    .gnt   (gnt),
    .idx   (idx)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ack_d   = '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          state_d = ST_SEND;
          data_d  = bus.i_data[idx*W +: W];
          ack_d   = gnt;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
          last_d  = idx;
`endif
        end
      end
      ST_SEND:    if (bus.i_accept)  state_d = ST_RELEASE;
      // Wait for accept to clear so the transmitter never sees back-to-back valid.
      ST_RELEASE: if (!bus.i_accept) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      ack_q   <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      last_q  <= IW'(N-1);
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.o_ack   = ack_q;
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_valid = (state_q == ST_SEND);
  assign bus.o_data  = data_q;
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` transmitter between `N` byte requesters. It captures the winning requester's byte and drives the transmitter's valid/data inputs. It also enforces the transmitter's handshake: valid is held until accept, then dropped and held low until accept clears. It sits between the requesting blocks (debug, status, log sources) and the single `uart_tx` instance on the board.

## Interface
- `N`, 4, number of requesters (2..16)
- `W`, 8, data width; fixed at 8 to match `uart_tx`
- `i_clk`  in  1  system clock, same clock as `uart_tx`
- `i_rst`  in  1  reset; one clock, reset is synchronous and active-high
- `i_req`  in  N  per-requester request; held high with data valid until acked
- `i_data`  in  N*8  requester bytes, requester k at bits [8k+7:8k]
- `o_ack`  out  N  one-hot, one-cycle pulse: requester's byte captured
- `o_busy`  out  1  high whenever state is not IDLE
- `o_valid`  out  1  to `uart_tx` `i_valid`
- `o_data`  out  8  to `uart_tx` `i_data`; registered, stable for the whole byte
- `i_accept`  in  1  from `uart_tx` `o_accept`

## Operation
- FSM states: IDLE, SEND, RELEASE.
- IDLE: if any `i_req` is high, select a winner. On that edge: `data_q` <= winner's byte, `last` <= winner, `o_ack[winner]` <= 1, state <= SEND. With no request, remain in IDLE.
- SEND: `o_valid`=1. On `i_accept`=1, state <= RELEASE.
- RELEASE: `o_valid`=0. On `i_accept`=0, state <= IDLE.
- Round-robin arbitration:
  - Search starts at `last+1` and wraps modulo N.
  - `last` resets to N-1, so requester 0 has first priority after reset.
  - A requester that drops `i_req` before it is granted is simply skipped. There is no penalty.
- The requester may change or drop `i_data`/`i_req` in the cycle after `o_ack`. The byte is held in `data_q`.
- A requester that keeps `i_req` high after its ack re-enters arbitration as a new byte. It gets lowest priority on the next pick.
- `o_data` = `data_q`. It changes only on an IDLE->SEND edge.

## Timing
- Reset values: state IDLE, `o_valid`=0, `o_data`=0, `o_ack`=0, `o_busy`=0, `last`=N-1.
- Request to `o_valid`:
  - A request seen in IDLE at edge t gives `o_valid`=1 and `o_ack` high from t+1. `o_ack` lasts exactly one cycle.
- Byte completion:
  - `i_accept` seen high at edge a gives `o_valid`=0 from a+1.
  - `i_accept` seen low at edge r gives IDLE from r+1.
  - The next grant is possible at the r+1 edge, so the minimum gap is 1 IDLE cycle between bytes.
- Simultaneous requests: exactly one winner per grant. `o_ack` is never multi-hot.
- `i_accept` high while in IDLE (should not occur): ignored. The FSM does not grant until it has left RELEASE.
- Reset mid-byte:
  - The FSM returns to IDLE and `o_valid` drops on the next cycle. The in-flight byte is lost and no ack is re-issued.
  - `uart_tx` must be reset in the same cycle by the system reset logic.
- `i_req` bits beyond N do not exist. N=1 is disallowed.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, with the lowest index winning. `last` is not used or updated.
  - Undefined (default): round-robin as described above.
- Handshake and timing are identical in both modes.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE/SEND/RELEASE), byte width constant `UART_W`=8.
- One sub-module `uart_arb_pick`, purely combinational:
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and binary index.
  - It compiles to a fixed lowest-index picker under the macro.
- The FSM, `data_q` and `last` registers live in `uart_tx_arb`.

## Test plan
- Single request: `i_req`=4'b0100, byte 0xA5 → `o_ack`=4'b0100 for one cycle, `o_data`=0xA5 held until `i_accept`. `o_valid` drops the cycle after accept and the FSM returns to IDLE after accept falls.
- All four requesting continuously, bytes 0x10/0x21/0x32/0x43 → grant order 0,1,2,3,0. `o_data` sequence matches.
  - Under `UART_TX_ARB_FIXED_PRIO_EN`: only requester 0 is served.
- Requester drops `i_req` before grant: `i_req`=4'b0011 then 4'b0010 → only requester 1 is acked. Requester 0 is never acked.
- Data change after ack: requester 2 changes byte from 0x5A to 0xFF one cycle after `o_ack` → `o_data` stays 0x5A for the whole byte.
- Accept stretch: hold `i_accept` high for 5 cycles in RELEASE → `o_valid` stays 0 and there is no new grant until `i_accept` falls, even with requests pending.
- Reset during SEND: assert `i_rst` for 1 cycle → next cycle `o_valid`=0, `o_data`=0, `o_busy`=0. The next grant goes to requester 0.
